// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: operation codes,
// bus widths, control constants and FSM state encodings.
package mem_lsu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian byte-lane steering: lane select, store replication,
// load extraction with sign/zero extension, and alignment checking.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          addr_lo,
    input  logic [RegBus-1:0]   store_data,
    input  logic [RegBus-1:0]   load_data,
    output logic                is_load,
    output logic                is_store,
    output logic                misaligned,
    output logic [3:0]          sel,
    output logic [RegBus-1:0]   wr_data,
    output logic [RegBus-1:0]   rd_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane 0 (addr 00) is the most significant byte.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_lane = load_data[31:24];
            2'b01:   byte_lane = load_data[23:16];
            2'b10:   byte_lane = load_data[15:8];
            default: byte_lane = load_data[7:0];
        endcase
        half_lane = addr_lo[1] ? load_data[15:0] : load_data[31:16];
    end

    // Decode the operation into lane select, data steering and alignment.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel        = 4'b0000;
        wr_data    = store_data;
        rd_data    = ZeroWord;
        case (aluop)
            EXE_LB_OP: begin
                is_load = 1'b1;
                sel     = 4'b1000 >> addr_lo;
                rd_data = {{24{byte_lane[7]}}, byte_lane};
            end
            EXE_LBU_OP: begin
                is_load = 1'b1;
                sel     = 4'b1000 >> addr_lo;
                rd_data = {24'h0, byte_lane};
            end
            EXE_LH_OP: begin
                is_load    = 1'b1;
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                rd_data    = {{16{half_lane[15]}}, half_lane};
            end
            EXE_LHU_OP: begin
                is_load    = 1'b1;
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                rd_data    = {16'h0, half_lane};
            end
            EXE_LW_OP: begin
                is_load    = 1'b1;
                misaligned = |addr_lo;
                sel        = 4'b1111;
                rd_data    = load_data;
            end
            EXE_SB_OP: begin
                is_store = 1'b1;
                sel      = 4'b1000 >> addr_lo;
                wr_data  = {4{store_data[7:0]}};
            end
            EXE_SH_OP: begin
                is_store   = 1'b1;
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wr_data    = {2{store_data[15:0]}};
            end
            EXE_SW_OP: begin
                is_store   = 1'b1;
                misaligned = |addr_lo;
                sel        = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack bus,
// stalls the pipeline while a transfer is outstanding and passes
// non-memory results straight through.
//
// state | meaning
// IDLE  | no transfer; pass-through, or launching an aligned memory op
// BUSY  | bus request outstanding, waiting for ack
// DONE  | transfer complete; load data held until MEM/WB accepts
// DRAIN | flushed while outstanding; wait for ack and discard it
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int BUS_AW = 32,
    parameter int BUS_DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    input  logic [7:0]            aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           reg2_i,
    input  logic [BUS_DW-1:0]     bus_data_i,
    input  logic                  bus_ack_i,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [BUS_AW-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [BUS_DW-1:0]     bus_data_o,
    output logic                  stallreq_o,
    output logic                  adel_o,
    output logic                  ades_o
);

    logic [1:0]          state;
    logic [7:0]          op_r;
    logic [1:0]          addr_lo_r;
    logic [31:0]         load_data_r;

    logic [7:0]          align_op;
    logic [1:0]          align_lo;
    logic                is_load;
    logic                is_store;
    logic                misaligned;
    logic [3:0]          sel;
    logic [31:0]         wr_data;
    logic [31:0]         rd_data;
    logic                start;
    logic                stall_int;
    logic                stall_unused;

    assign stall_unused = ^{stall[5], stall[3:0]};

    // Once a transfer is launched, decode from the captured op so the
    // extraction does not depend on the upstream register staying put.
    assign align_op = (state == ST_IDLE) ? aluop_i : op_r;
    assign align_lo = (state == ST_IDLE) ? mem_addr_i[1:0] : addr_lo_r;

    mem_lsu_align u_align (
        .aluop      (align_op),
        .addr_lo    (align_lo),
        .store_data (reg2_i),
        .load_data  (bus_data_i),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .sel        (sel),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    assign start = (state == ST_IDLE) && (is_load || is_store) && !misaligned && !flush;

    // Stall while launching, waiting or draining; DONE releases the pipeline.
    always_comb begin
        stall_int = NoStop;
        case (state)
            ST_IDLE:  stall_int = start;
            ST_BUSY:  stall_int = Stop;
            ST_DRAIN: stall_int = Stop;
            default:  stall_int = NoStop;
        endcase
    end

    // Transfer FSM and registered bus drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state       <= ST_IDLE;
            op_r        <= 8'h00;
            addr_lo_r   <= 2'b00;
            load_data_r <= ZeroWord;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= 4'b0000;
            bus_data_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_BUSY;
                        op_r       <= aluop_i;
                        addr_lo_r  <= mem_addr_i[1:0];
                        bus_req_o  <= 1'b1;
                        bus_we_o   <= is_store;
                        bus_addr_o <= {mem_addr_i[BUS_AW-1:2], 2'b00};
                        bus_sel_o  <= sel;
                        bus_data_o <= wr_data;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state       <= ST_DONE;
                            load_data_r <= rd_data;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || !stall[4]) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Pass-through to MEM/WB; reset forces every output to zero at once.
    always_comb begin
        wd_o       = rst ? 5'd0 : wd_i;
        hi_o       = rst ? ZeroWord : hi_i;
        lo_o       = rst ? ZeroWord : lo_i;
        whilo_o    = rst ? WriteDisable : whilo_i;
        stallreq_o = rst ? NoStop : stall_int;
        adel_o     = !rst && (state == ST_IDLE) && is_load && misaligned;
        ades_o     = !rst && (state == ST_IDLE) && is_store && misaligned;
        wreg_o     = (rst || adel_o || ades_o || stall_int || state == ST_DRAIN)
                     ? WriteDisable : wreg_i;
        if (rst)
            wdata_o = ZeroWord;
        else if (state == ST_DONE && is_load)
            wdata_o = load_data_r;
        else
            wdata_o = wdata_i;
    end

endmodule
